// File: rtl/sr_hazard_ctrl.sv
// Purpose : pipeline sequencing controller for the 4-stage sr_cpu (PC advance, decode bubble, operand forwarding).
// Latency : pcWrite/pcSel/bubbleD/fwd/busy combinational from state and inputs; stallCnt/brErr registered (1 cycle).
// Backpr. : a branch accepted from decode freezes fetch for RESOLVE_STAGES cycles; decode receives bubbles until it resolves.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   dValid_i, branch_d_i        decode holds a real instruction / that instruction is a branch
//   rs1_d_i, rs2_d_i            decode source register indices
//   rd_e_i, regWrite_e_i        execute destination and write enable
//   rd_w_i, regWrite_w_i        writeback destination and write enable
//   resolveValid_w_i, taken_w_i branch outcome from writeback
//   pcWrite_o, pcSel_o          PC load enable, PC source (0 pcPlus4, 1 branch target)
//   bubbleD_o                   decode register loads a NOP
//   fwdA_o, fwdB_o              operand select: 0 regfile, 1 execute, 2 writeback
//   busy_o, stallCnt_o, brErr_o branch in flight, saturating stall count, sticky missing-resolve flag
module sr_hazard_ctrl #(
    parameter int RESOLVE_STAGES = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dValid_i,
    input  logic             branch_d_i,
    input  logic [4:0]       rs1_d_i,
    input  logic [4:0]       rs2_d_i,
    input  logic [4:0]       rd_e_i,
    input  logic             regWrite_e_i,
    input  logic [4:0]       rd_w_i,
    input  logic             regWrite_w_i,
    input  logic             resolveValid_w_i,
    input  logic             taken_w_i,
    output logic             pcWrite_o,
    output logic             pcSel_o,
    output logic             bubbleD_o,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stallCnt_o,
    output logic             brErr_o
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // Down-counter width; at least one bit so RESOLVE_STAGES=1 still builds.
    localparam int              CW        = (RESOLVE_STAGES > 1) ? $clog2(RESOLVE_STAGES) : 1;
    localparam logic [CW-1:0]   CNT_INIT  = CW'(RESOLVE_STAGES - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    logic             r_state;
    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_br_err;

    logic w_accept;
    logic w_wait;
    logic w_resolve;
    logic w_taken;

    // Accept is masked by rst_n so a branch sitting in decode during reset
    // cannot freeze fetch before the pipeline has started.
    assign w_accept  = rst_n & (r_state == ST_RUN) & dValid_i & branch_d_i;
    assign w_wait    = (r_state == ST_WAIT);
    assign w_resolve = w_wait & (r_cnt == '0);
    // A missing resolveValid is treated as not taken.
    assign w_taken   = w_resolve & resolveValid_w_i & taken_w_i;

    always_comb begin
        pcWrite_o = 1'b1;
        pcSel_o   = 1'b0;
        bubbleD_o = 1'b0;
        if (w_accept) begin
            // Fetch holds branch+4 while the branch travels to writeback.
            pcWrite_o = 1'b0;
            bubbleD_o = 1'b1;
        end else if (w_wait && !w_resolve) begin
            pcWrite_o = 1'b0;
            bubbleD_o = 1'b1;
        end else if (w_taken) begin
            // Redirect and squash the held branch+4 instruction.
            pcSel_o   = 1'b1;
            bubbleD_o = 1'b1;
        end
    end

    assign busy_o = w_wait;

    // Execute result is newer than writeback, so it wins; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] rd_e, input logic we_e,
                                           input logic [4:0] rd_w, input logic we_w);
        if (we_e && (rd_e != 5'd0) && (rd_e == src))
            return 2'd1;
        else if (we_w && (rd_w != 5'd0) && (rd_w == src))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign fwdA_o = fwd_sel(rs1_d_i, rd_e_i, regWrite_e_i, rd_w_i, regWrite_w_i);
    assign fwdB_o = fwd_sel(rs2_d_i, rd_e_i, regWrite_e_i, rd_w_i, regWrite_w_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_INIT;
        end else if (w_resolve) begin
            r_state <= ST_RUN;
        end else if (w_wait) begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((w_accept || w_wait) && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_err <= 1'b0;
        end else if (w_resolve && !resolveValid_w_i) begin
            r_br_err <= 1'b1;
        end
    end

    assign stallCnt_o = r_stall_cnt;
    assign brErr_o    = r_br_err;

endmodule

// File: tb/tb_sr_hazard_ctrl.sv
// Purpose : directed self-checking bench for sr_hazard_ctrl (default build plus a CNT_W=2 build).
// Latency : expectations queued when stimulus is driven, compared 2 ns later with the clock low.
// Backpr. : none; every step is exactly one clock cycle.
module tb_sr_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       dValid_i, branch_d_i;
    logic [4:0] rs1_d_i, rs2_d_i, rd_e_i, rd_w_i;
    logic       regWrite_e_i, regWrite_w_i;
    logic       resolveValid_w_i, taken_w_i;

    logic        pcWrite_o, pcSel_o, bubbleD_o, busy_o, brErr_o;
    logic [1:0]  fwdA_o, fwdB_o;
    logic [15:0] stallCnt_o;

    logic        pcWrite_1, pcSel_1, bubbleD_1, busy_1, brErr_1;
    logic [1:0]  fwdA_1, fwdB_1;
    logic [1:0]  stallCnt_1;

    sr_hazard_ctrl #(.RESOLVE_STAGES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dValid_i(dValid_i), .branch_d_i(branch_d_i),
        .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i),
        .rd_e_i(rd_e_i), .regWrite_e_i(regWrite_e_i),
        .rd_w_i(rd_w_i), .regWrite_w_i(regWrite_w_i),
        .resolveValid_w_i(resolveValid_w_i), .taken_w_i(taken_w_i),
        .pcWrite_o(pcWrite_o), .pcSel_o(pcSel_o), .bubbleD_o(bubbleD_o),
        .fwdA_o(fwdA_o), .fwdB_o(fwdB_o), .busy_o(busy_o),
        .stallCnt_o(stallCnt_o), .brErr_o(brErr_o)
    );

    sr_hazard_ctrl #(.RESOLVE_STAGES(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .dValid_i(dValid_i), .branch_d_i(branch_d_i),
        .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i),
        .rd_e_i(rd_e_i), .regWrite_e_i(regWrite_e_i),
        .rd_w_i(rd_w_i), .regWrite_w_i(regWrite_w_i),
        .resolveValid_w_i(resolveValid_w_i), .taken_w_i(taken_w_i),
        .pcWrite_o(pcWrite_1), .pcSel_o(pcSel_1), .bubbleD_o(bubbleD_1),
        .fwdA_o(fwdA_1), .fwdB_o(fwdB_1), .busy_o(busy_1),
        .stallCnt_o(stallCnt_1), .brErr_o(brErr_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pcw, pcs, bub, busy, err;
        logic [1:0]  fa, fb, sc2;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic set_fwd(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rde, input logic we,
                           input logic [4:0] rdw, input logic ww);
        rs1_d_i = rs1; rs2_d_i = rs2;
        rd_e_i = rde; regWrite_e_i = we;
        rd_w_i = rdw; regWrite_w_i = ww;
    endtask

    // Drive one cycle of control inputs, queue its expectation, check, advance.
    task automatic step(input string tag,
                        input logic dv, input logic br, input logic rv, input logic tk,
                        input logic pcw, input logic pcs, input logic bub, input logic busy,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [15:0] sc, input logic [1:0] sc2, input logic err);
        exp_t e;
        dValid_i = dv; branch_d_i = br; resolveValid_w_i = rv; taken_w_i = tk;
        e.tag = tag; e.pcw = pcw; e.pcs = pcs; e.bub = bub; e.busy = busy;
        e.fa = fa; e.fb = fb; e.sc = sc; e.sc2 = sc2; e.err = err;
        q.push_back(e);
        #2;
        e = q.pop_front();
        chk({e.tag, ".pcWrite"},  16'(pcWrite_o),  16'(e.pcw));
        chk({e.tag, ".pcSel"},    16'(pcSel_o),    16'(e.pcs));
        chk({e.tag, ".bubbleD"},  16'(bubbleD_o),  16'(e.bub));
        chk({e.tag, ".busy"},     16'(busy_o),     16'(e.busy));
        chk({e.tag, ".fwdA"},     16'(fwdA_o),     16'(e.fa));
        chk({e.tag, ".fwdB"},     16'(fwdB_o),     16'(e.fb));
        chk({e.tag, ".stallCnt"}, stallCnt_o,      e.sc);
        chk({e.tag, ".brErr"},    16'(brErr_o),    16'(e.err));
        chk({e.tag, ".sat.pcWrite"},  16'(pcWrite_1),  16'(e.pcw));
        chk({e.tag, ".sat.pcSel"},    16'(pcSel_1),    16'(e.pcs));
        chk({e.tag, ".sat.bubbleD"},  16'(bubbleD_1),  16'(e.bub));
        chk({e.tag, ".sat.busy"},     16'(busy_1),     16'(e.busy));
        chk({e.tag, ".sat.fwdA"},     16'(fwdA_1),     16'(e.fa));
        chk({e.tag, ".sat.fwdB"},     16'(fwdB_1),     16'(e.fb));
        chk({e.tag, ".sat.stallCnt"}, 16'(stallCnt_1), 16'(e.sc2));
        chk({e.tag, ".sat.brErr"},    16'(brErr_1),    16'(e.err));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        dValid_i = 1'b0; branch_d_i = 1'b0; resolveValid_w_i = 1'b0; taken_w_i = 1'b0;
        set_fwd(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

        // A branch in decode during reset must not stall fetch.
        //       tag          dv br rv tk  pcw pcs bub bsy fa fb  sc  sc2 err
        step("rst",          1, 1, 0, 0,  1,  0,  0,  0,  0, 0,  0,  0,  0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++)
            step("idle",     0, 0, 0, 0,  1,  0,  0,  0,  0, 0,  0,  0,  0);

        // Taken branch, RESOLVE_STAGES=2: stall, stall, redirect.
        step("tk_acc",       1, 1, 0, 0,  0,  0,  1,  0,  0, 0,  0,  0,  0);
        step("tk_wait",      1, 1, 0, 0,  0,  0,  1,  1,  0, 0,  1,  1,  0);
        step("tk_res",       0, 0, 1, 1,  1,  1,  1,  1,  0, 0,  2,  2,  0);
        step("tk_run",       0, 0, 0, 0,  1,  0,  0,  0,  0, 0,  3,  3,  0);

        // Not taken, then an immediate back-to-back branch.
        step("nt_acc",       1, 1, 0, 0,  0,  0,  1,  0,  0, 0,  3,  3,  0);
        step("nt_wait",      0, 0, 0, 0,  0,  0,  1,  1,  0, 0,  4,  3,  0);
        step("nt_res",       0, 0, 1, 0,  1,  0,  0,  1,  0, 0,  5,  3,  0);
        step("b2b_acc",      1, 1, 0, 0,  0,  0,  1,  0,  0, 0,  6,  3,  0);
        step("b2b_wait",     0, 0, 0, 0,  0,  0,  1,  1,  0, 0,  7,  3,  0);
        // Resolve slot without resolveValid: not taken even with taken_w_i high.
        step("nv_res",       0, 0, 0, 1,  1,  0,  0,  1,  0, 0,  8,  3,  0);
        step("err_set",      0, 0, 0, 0,  1,  0,  0,  0,  0, 0,  9,  3,  1);
        step("err_acc",      1, 1, 0, 0,  0,  0,  1,  0,  0, 0,  9,  3,  1);
        step("err_wait",     0, 0, 0, 0,  0,  0,  1,  1,  0, 0, 10,  3,  1);
        step("err_res",      0, 0, 1, 1,  1,  1,  1,  1,  0, 0, 11,  3,  1);
        step("err_hold",     0, 0, 0, 0,  1,  0,  0,  0,  0, 0, 12,  3,  1);

        // Reset in the cycle after accept: no redirect, everything cleared.
        step("rw_acc",       1, 1, 0, 0,  0,  0,  1,  0,  0, 0, 12,  3,  1);
        rst_n = 1'b0;
        step("rw_rst",       0, 0, 1, 1,  1,  0,  0,  0,  0, 0,  0,  0,  0);
        rst_n = 1'b1;
        step("rw_run",       0, 0, 0, 0,  1,  0,  0,  0,  0, 0,  0,  0,  0);

        // Forwarding priority and x0 exclusion.
        set_fwd(5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
        step("fw_e",         0, 0, 0, 0,  1,  0,  0,  0,  1, 1,  0,  0,  0);
        set_fwd(5'd5, 5'd5, 5'd5, 1'b0, 5'd5, 1'b1);
        step("fw_w",         0, 0, 0, 0,  1,  0,  0,  0,  2, 2,  0,  0,  0);
        set_fwd(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step("fw_x0",        0, 0, 0, 0,  1,  0,  0,  0,  0, 0,  0,  0,  0);
        set_fwd(5'd3, 5'd4, 5'd4, 1'b1, 5'd3, 1'b1);
        step("fw_mix",       0, 0, 0, 0,  1,  0,  0,  0,  2, 1,  0,  0,  0);
        set_fwd(5'd3, 5'd4, 5'd3, 1'b0, 5'd4, 1'b0);
        step("fw_none",      0, 0, 0, 0,  1,  0,  0,  0,  0, 0,  0,  0,  0);

        // Forwarding while a branch is in flight; 6 stall cycles saturate CNT_W=2 at 3.
        set_fwd(5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
        step("sat_acc",      1, 1, 0, 0,  0,  0,  1,  0,  1, 1,  0,  0,  0);
        set_fwd(5'd5, 5'd5, 5'd5, 1'b0, 5'd5, 1'b1);
        step("sat_wait",     0, 0, 0, 0,  0,  0,  1,  1,  2, 2,  1,  1,  0);
        set_fwd(5'd3, 5'd4, 5'd4, 1'b1, 5'd3, 1'b1);
        step("sat_res",      0, 0, 1, 1,  1,  1,  1,  1,  2, 1,  2,  2,  0);
        set_fwd(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("sat_acc2",     1, 1, 0, 0,  0,  0,  1,  0,  0, 0,  3,  3,  0);
        step("sat_wait2",    0, 0, 0, 0,  0,  0,  1,  1,  0, 0,  4,  3,  0);
        step("sat_res2",     0, 0, 1, 0,  1,  0,  0,  1,  0, 0,  5,  3,  0);
        step("sat_end",      0, 0, 0, 0,  1,  0,  0,  0,  0, 0,  6,  3,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
